onewire_read: RTL and testbench

Bit-level 1-Wire master read engine: issues eight read time slots on the bus and assembles the slave's response byte, LSB first. Sits beside the byte write engine under the 1-Wire master sequencer and shares the same open-drain `drive_low` bus driver (the sequencer ORs/muxes the two). Same enable/done level handshake as the write engine, so the sequencer drives both identically.

---
 rtl/onewire_pkg.sv | 26 ++
 rtl/onewire_read_if.sv | 29 ++
 rtl/onewire_sync.sv | 29 ++
 rtl/onewire_read.sv | 148 ++++++++++++++
 tb/tb_onewire_read.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/onewire_pkg.sv
// Shared 1-Wire master definitions: bus timing constants used by the read, write
// and reset engines, plus the read engine's state encoding.
package onewire_pkg;

    localparam int CLKS_PER_US = 27;

    // Read time slot, all measured from the master's falling edge.
    localparam int T_LOW_US    = 6;
    localparam int T_SAMPLE_US = 15;
    localparam int T_SLOT_US   = 70;

    localparam int RD_BITS = 8;

    typedef enum logic [2:0] {
        RD_IDLE        = 3'd0,
        RD_LOW         = 3'd1,
        RD_WAIT_SAMPLE = 3'd2,
        RD_RECOVER     = 3'd3,
        RD_DONE        = 3'd4
    } rd_state_t;

    function automatic int us_to_cyc(input int us, input int clks_per_us);
        return us * clks_per_us;
    endfunction

endpackage

// File: rtl/onewire_read_if.sv
// Sequencer <-> read engine connection: level enable/done handshake, raw bus level
// in, open-drain pull-down request out, and the received byte.
interface onewire_read_if;

    logic       enable;
    logic       bus_in;
    logic       drive_low;
    logic       done;
    logic [7:0] data;

    // Sequencer side.
    modport master (
        output enable,
        output bus_in,
        input  drive_low,
        input  done,
        input  data
    );

    // Read engine side.
    modport slave (
        input  enable,
        input  bus_in,
        output drive_low,
        output done,
        output data
    );

endinterface

// File: rtl/onewire_sync.sv
// Two-flop synchronizer for the asynchronous 1-Wire line; resets to the idle
// (pulled-up) level so a reset never looks like a slave pulling the bus low.
module onewire_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            // NOTE: non-blocking keeps this a two-stage chain; with blocking
            // assignments sync_q would take async_i in the same edge.
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/onewire_read.sv
// 1-Wire master byte read engine: issues eight read time slots and assembles the
// slave's response LSB first, under the sequencer's level enable/done handshake.
module onewire_read #(
    parameter int CLKS_PER_US = onewire_pkg::CLKS_PER_US,
    parameter int T_LOW_US    = onewire_pkg::T_LOW_US,
    parameter int T_SAMPLE_US = onewire_pkg::T_SAMPLE_US,
    parameter int T_SLOT_US   = onewire_pkg::T_SLOT_US
) (
    input  logic           clk,
    input  logic           rst,
    onewire_read_if.slave  rd_if
);

    import onewire_pkg::*;

    localparam int LOW_CYC    = us_to_cyc(T_LOW_US, CLKS_PER_US);
    localparam int SAMPLE_CYC = us_to_cyc(T_SAMPLE_US, CLKS_PER_US);
    localparam int SLOT_CYC   = us_to_cyc(T_SLOT_US, CLKS_PER_US);
    localparam int CNT_W      = $clog2(SLOT_CYC);

    localparam logic [CNT_W-1:0] LOW_END    = CNT_W'(LOW_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_END = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_END   = CNT_W'(SLOT_CYC - 1);
    localparam logic [2:0]       LAST_BIT   = 3'(RD_BITS - 1);

    rd_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             drive_low_q;
    logic             done_q;
    logic             bus_sync;

    onewire_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (rd_if.bus_in),
        .sync_o  (bus_sync)
    );

    // The counter runs from the slot's falling edge, so every threshold is
    // measured from the same origin and the counter only clears at slot end.
    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            drive_low_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                RD_IDLE: begin
                    drive_low_q <= 1'b0;
                    done_q      <= 1'b0;
                    cnt_q       <= '0;
                    idx_q       <= '0;
                    if (rd_if.enable) begin
                        state_q     <= RD_LOW;
                        drive_low_q <= 1'b1;
                    end
                end

                RD_LOW: begin
                    if (!rd_if.enable) begin
                        state_q     <= RD_IDLE;
                        drive_low_q <= 1'b0;
                        cnt_q       <= '0;
                        idx_q       <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_q == LOW_END) begin
                            state_q     <= RD_WAIT_SAMPLE;
                            drive_low_q <= 1'b0;
                        end
                    end
                end

                RD_WAIT_SAMPLE: begin
                    drive_low_q <= 1'b0;
                    if (!rd_if.enable) begin
                        state_q <= RD_IDLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_q == SAMPLE_END) begin
                            shift_q[idx_q] <= bus_sync;
                            state_q        <= RD_RECOVER;
                        end
                    end
                end

                RD_RECOVER: begin
                    drive_low_q <= 1'b0;
                    if (!rd_if.enable) begin
                        state_q <= RD_IDLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else if (cnt_q == SLOT_END) begin
                        cnt_q <= '0;
                        if (idx_q == LAST_BIT) begin
                            state_q <= RD_DONE;
                            done_q  <= 1'b1;
                            data_q  <= shift_q;
                        end else begin
                            idx_q       <= idx_q + 1'b1;
                            state_q     <= RD_LOW;
                            drive_low_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                RD_DONE: begin
                    drive_low_q <= 1'b0;
                    // Holding done until enable falls forces a one-cycle gap
                    // between back-to-back reads.
                    if (!rd_if.enable) begin
                        state_q <= RD_IDLE;
                        done_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= RD_IDLE;
                    drive_low_q <= 1'b0;
                    done_q      <= 1'b0;
                    cnt_q       <= '0;
                    idx_q       <= '0;
                end
            endcase
        end
    end

    assign rd_if.drive_low = drive_low_q;
    assign rd_if.done      = done_q;
    assign rd_if.data      = data_q;

endmodule

// File: tb/tb_onewire_read.sv
// Directed bench for onewire_read: wired-AND bus with a slot-tracking slave model,
// checks byte values, slot timing, abort, reset and the done handshake.
module tb_onewire_read;

    import onewire_pkg::*;

    localparam int SLOT_CYC  = 1890;
    localparam int LOW_CYC   = 162;
    localparam int BYTE_CYC  = 8 * SLOT_CYC;
    localparam int SLAVE_LOW = 30 * 27;

    logic clk = 1'b0;
    logic rst = 1'b1;

    onewire_read_if rd_if ();

    onewire_read dut (
        .clk   (clk),
        .rst   (rst),
        .rd_if (rd_if)
    );

    always #5 clk = ~clk;

    // 0: bus released, 1: slave answers with pattern, 2: slave holds line low
    int         mode    = 0;
    logic [7:0] pattern = 8'hA5;
    logic       slave_low = 1'b0;

    assign rd_if.bus_in = ~(rd_if.drive_low | slave_low);

    int tests = 0;
    int fails = 0;

    // Slave / timing monitor, updated away from the active edge.
    int   slot_cnt = 0;
    int   pos      = 0;
    int   hi       = 0;
    int   wmin     = 99999;
    int   wmax     = 0;
    int   pmin     = 99999;
    int   pmax     = 0;
    logic prev_dl  = 1'b0;

    always @(negedge clk) begin
        if (!rd_if.enable) begin
            slot_cnt = 0;
            pos      = 0;
            hi       = 0;
            wmin     = 99999;
            wmax     = 0;
            pmin     = 99999;
            pmax     = 0;
        end else begin
            if (rd_if.drive_low && !prev_dl) begin
                if (slot_cnt > 0) begin
                    if (pos + 1 < pmin) pmin = pos + 1;
                    if (pos + 1 > pmax) pmax = pos + 1;
                end
                slot_cnt = slot_cnt + 1;
                pos      = 0;
                hi       = 1;
            end else begin
                pos = pos + 1;
                if (rd_if.drive_low) begin
                    hi = hi + 1;
                end else if (prev_dl) begin
                    if (hi < wmin) wmin = hi;
                    if (hi > wmax) wmax = hi;
                end
            end
        end
        prev_dl   = rd_if.drive_low;
        slave_low = (mode == 2) ||
                    (mode == 1 && slot_cnt > 0 && slot_cnt <= 8 &&
                     !pattern[slot_cnt-1] && pos < SLAVE_LOW);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a read and waits (bounded) for done; reports latency from first
    // drive_low rise and the negedge index at which that rise was seen.
    task automatic run_read(input string tag, input logic [7:0] exp_data);
        int n      = 0;
        int rise_n = -1;
        rd_if.enable = 1'b1;
        while (n < BYTE_CYC + 1000) begin
            @(negedge clk);
            n++;
            if (rd_if.drive_low && rise_n < 0) rise_n = n;
            if (rd_if.done) break;
        end
        check({tag, "_done"},       32'(rd_if.done), 32'd1);
        check({tag, "_first_rise"}, 32'(rise_n),     32'd1);
        check({tag, "_latency"},    32'(n - rise_n), 32'(BYTE_CYC));
        check({tag, "_data"},       32'(rd_if.data), 32'(exp_data));
        check({tag, "_dl_at_done"}, 32'(rd_if.drive_low), 32'd0);
    endtask

    task automatic finish_read(input string tag);
        rd_if.enable = 1'b0;
        @(negedge clk);
        check({tag, "_done_fall"}, 32'(rd_if.done), 32'd0);
    endtask

    initial begin
        int bad;
        int dl_seen;

        rd_if.enable = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_drive_low", 32'(rd_if.drive_low), 32'd0);
        check("rst_done",      32'(rd_if.done),      32'd0);
        check("rst_data",      32'(rd_if.data),      32'h00);
        check("rst_state",     32'(dut.state_q),     32'(RD_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Slave answers 0xA5, then done is held with enable high.
        mode = 1;
        pattern = 8'hA5;
        run_read("a5", 8'hA5);
        bad = 0;
        dl_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (!rd_if.done) bad++;
            if (rd_if.drive_low) dl_seen++;
        end
        check("hold_done_low_cycles", 32'(bad),     32'd0);
        check("hold_new_slots",       32'(dl_seen), 32'd0);
        finish_read("a5");

        // Abort during the third slot's low pulse.
        rd_if.enable = 1'b1;
        repeat (2 * SLOT_CYC + 1 + 50) @(negedge clk);
        check("abort_pre_slot",     32'(slot_cnt),        32'd3);
        check("abort_pre_dl",       32'(rd_if.drive_low), 32'd1);
        rd_if.enable = 1'b0;
        @(negedge clk);
        check("abort_dl",    32'(rd_if.drive_low), 32'd0);
        check("abort_state", 32'(dut.state_q),     32'(RD_IDLE));
        check("abort_data",  32'(rd_if.data),      32'hA5);
        check("abort_done",  32'(rd_if.done),      32'd0);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (rd_if.done || rd_if.drive_low) bad++;
        end
        check("abort_quiet", 32'(bad), 32'd0);

        // Slave holds the line low through every sample.
        mode = 2;
        run_read("stuck", 8'h00);
        finish_read("stuck");

        // Bus released: all ones, plus pulse width and slot period.
        mode = 0;
        run_read("ff", 8'hFF);
        check("ff_width_min",  32'(wmin), 32'(LOW_CYC));
        check("ff_width_max",  32'(wmax), 32'(LOW_CYC));
        check("ff_period_min", 32'(pmin), 32'(SLOT_CYC));
        check("ff_period_max", 32'(pmax), 32'(SLOT_CYC));
        finish_read("ff");

        // Reset in the middle of a low pulse, enable still high.
        rd_if.enable = 1'b1;
        repeat (SLOT_CYC + 1 + 20) @(negedge clk);
        check("rst_mid_pre_dl", 32'(rd_if.drive_low), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_dl",   32'(rd_if.drive_low), 32'd0);
        check("rst_mid_done", 32'(rd_if.done),      32'd0);
        check("rst_mid_data", 32'(rd_if.data),      32'h00);
        repeat (3) @(negedge clk);
        check("rst_wins_dl",  32'(rd_if.drive_low), 32'd0);
        rd_if.enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        mode = 1;
        pattern = 8'h3C;
        run_read("after_rst", 8'h3C);
        finish_read("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
